// File: rtl/mpadder_modred.sv
// Final modular-reduction stage after the multi-precision adder: returns X mod M
// for X < 2*M with one conditional subtraction split across two limbs.
module mpadder_modred #(
  parameter int DATA_W = 1027,
  parameter int LIMB_W = 514
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W:0]   in_x,
  input  logic [DATA_W-1:0] in_m,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done
);

  // state   | meaning
  // IDLE    | waiting for start; operands captured on start
  // LOW     | subtract low limb, register difference and carry
  // HIGH    | subtract high limb, select X-M or X, pulse done

  localparam int X_W = 2 * LIMB_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [X_W-1:0]    x_q;
  logic [X_W-1:0]    m_q;
  logic [LIMB_W-1:0] d_lo_q;
  logic              c_lo_q;

  logic              load;
  logic              step_lo;
  logic              step_hi;

  logic [LIMB_W:0]   sum_lo;
  logic [LIMB_W:0]   sum_hi;
  logic [X_W-1:0]    diff;
  logic              unused_diff;

  // Subtraction as X + ~M + 1; a carry out of the top limb means no borrow (X >= M).
  assign sum_lo = {1'b0, x_q[LIMB_W-1:0]} + {1'b0, ~m_q[LIMB_W-1:0]}
                + {{LIMB_W{1'b0}}, 1'b1};
  assign sum_hi = {1'b0, x_q[X_W-1:LIMB_W]} + {1'b0, ~m_q[X_W-1:LIMB_W]}
                + {{LIMB_W{1'b0}}, c_lo_q};
  assign diff        = {sum_hi[LIMB_W-1:0], d_lo_q};
  assign unused_diff = ^diff[X_W-1:DATA_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOW;
      ST_LOW:  state_nxt = ST_HIGH;
      ST_HIGH: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ST_LOW) || (state == ST_HIGH);
    load    = (state == ST_IDLE) && start;
    step_lo = (state == ST_LOW);
    step_hi = (state == ST_HIGH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q    <= '0;
      m_q    <= '0;
      d_lo_q <= '0;
      c_lo_q <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= step_hi;
      if (load) begin
        x_q <= X_W'(in_x);
        m_q <= X_W'(in_m);
      end
      if (step_lo) begin
        {c_lo_q, d_lo_q} <= sum_lo;
      end
      if (step_hi) begin
        result <= sum_hi[LIMB_W] ? diff[DATA_W-1:0] : x_q[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mpadder_modred.sv
// Directed-vector and corner-sequence bench for mpadder_modred.
module tb_mpadder_modred;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [1027:0] in_x;
  logic [1026:0] in_m;
  logic [1026:0] result;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  mpadder_modred #(.DATA_W(1027), .LIMB_W(514)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_x   (in_x),
    .in_m   (in_m),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1027:0] x;
    logic [1026:0] m;
    logic [1026:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [1026:0] got, input logic [1026:0] exp);
    logic [1026:0] d;
    logic [1026:0] g_sh;
    logic [1026:0] e_sh;
    int idx;
    int base;
    checks++;
    if (got !== exp) begin
      errors++;
      d = got ^ exp;
      idx = 0;
      for (int i = 1026; i >= 0; i--) if (d[i] !== 1'b0) idx = i;
      base = (idx / 128) * 128;
      g_sh = got >> base;
      e_sh = exp >> base;
      $display("FAIL %s first_diff_bit %0d got[%0d+:128] %h exp[%0d+:128] %h",
               name, idx, base, g_sh[127:0], base, e_sh[127:0]);
    end
  endtask

  task automatic run_op(input logic [1027:0] x, input logic [1026:0] m,
                        output logic [1026:0] res, output int lat, output int busy_cnt);
    @(negedge clk);
    in_x = x;
    in_m = m;
    start = 1'b1;
    lat = -1;
    busy_cnt = 0;
    res = '0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        start = 1'b0;
        in_x = '1;
        in_m = '1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
    end
  endtask

  function automatic logic [1027:0] rand_wide();
    logic [1027:0] v;
    v = '0;
    for (int i = 0; i < 33; i++) v = {v[995:0], 32'($urandom())};
    return v;
  endfunction

  initial begin
    logic [1027:0] one;
    logic [1026:0] res;
    logic [1026:0] m;
    logic [1027:0] x;
    logic [1027:0] tmp;
    int lat;
    int bcnt;
    int dcnt;

    one = 1028'd1;
    vecs[0] = '{x: 1028'd5,            m: 1027'd7,                     exp: 1027'd5};
    vecs[1] = '{x: 1028'd7,            m: 1027'd7,                     exp: 1027'd0};
    vecs[2] = '{x: 1028'd13,           m: 1027'd7,                     exp: 1027'd6};
    vecs[3] = '{x: one << 1027,        m: 1027'((one << 1026) + 1),    exp: 1027'((one << 1026) - 1)};
    vecs[4] = '{x: (one << 1028) - 3,  m: 1027'((one << 1027) - 1),    exp: 1027'((one << 1027) - 2)};
    vecs[5] = '{x: one << 514,         m: 1027'd1,                     exp: 1027'((one << 514) - 1)};
    vecs[6] = '{x: (one << 514) - 1,   m: 1027'(one << 514),           exp: 1027'((one << 514) - 1)};
    vecs[7] = '{x: 1028'd0,            m: 1027'd7,                     exp: 1027'd0};
    vecs[8] = '{x: 1028'd6,            m: 1027'd7,                     exp: 1027'd6};
    vecs[9] = '{x: 1028'd123,          m: 1027'd0,                     exp: 1027'd123};

    resetn = 1'b0;
    start  = 1'b0;
    in_x   = '0;
    in_m   = '0;
    #12;
    chk_val("reset_result", result, '0);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_done", int'(done), 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].x, vecs[i].m, res, lat, bcnt);
      chk_int($sformatf("vec%0d_latency", i), lat, 3);
      chk_int($sformatf("vec%0d_busy_cycles", i), bcnt, 2);
      chk_val($sformatf("vec%0d_result", i), res, vecs[i].exp);
      @(posedge clk);
      #1;
      chk_int($sformatf("vec%0d_done_pulse", i), int'(done), 0);
      @(posedge clk);
      #1;
      chk_val($sformatf("vec%0d_result_hold", i), result, vecs[i].exp);
    end

    // start held for six edges: two back-to-back operations, inputs swapped while busy
    @(negedge clk);
    in_x = 1028'd5;
    in_m = 1027'd7;
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk_int($sformatf("hold_done_edge%0d", k), int'(done), (k == 3 || k == 6) ? 1 : 0);
      if (k == 3) chk_val("hold_result_first", result, 1027'd5);
      if (k == 6) chk_val("hold_result_second", result, 1027'd6);
      if (k == 1) begin
        in_x = 1028'd13;
        in_m = 1027'd7;
      end
      if (k == 4) begin
        in_x = 1028'd0;
        in_m = 1027'd1;
      end
      if (k == 6) start = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_int("hold_idle_busy", int'(busy), 0);

    // reset while in HIGH aborts the operation
    @(negedge clk);
    in_x = 1028'd13;
    in_m = 1027'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk_int("midrst_busy_before", int'(busy), 1);
    resetn = 1'b0;
    #1;
    chk_int("midrst_busy", int'(busy), 0);
    chk_val("midrst_result", result, '0);
    chk_int("midrst_done", int'(done), 0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk_int("midrst_no_done", dcnt, 0);
    chk_val("midrst_result_after", result, '0);

    for (int n = 0; n < 300; n++) begin
      tmp = rand_wide() >> $urandom_range(1, 1000);
      m = tmp[1026:0];
      if (m == '0) m = 1027'd1;
      x = rand_wide() % {m, 1'b0};
      tmp = (x >= {1'b0, m}) ? (x - {1'b0, m}) : x;
      run_op(x, m, res, lat, bcnt);
      chk_int($sformatf("rand%0d_latency", n), lat, 3);
      chk_val($sformatf("rand%0d_result", n), res, tmp[1026:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
